// File: rtl/cu_pkg.sv
// Shared encodings for the control unit: opcodes, ALU function codes, FSM states
// and the decoded-instruction bundle handed from instr_decoder to control_unit.
package cu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned FS_W    = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_AND  = 4'h3;
    localparam logic [OP_W-1:0] OP_OR   = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h6;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h7;
    localparam logic [OP_W-1:0] OP_LD   = 4'h8;
    localparam logic [OP_W-1:0] OP_ST   = 4'h9;
    localparam logic [OP_W-1:0] OP_BZ   = 4'hA;
    localparam logic [OP_W-1:0] OP_BNZ  = 4'hB;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
    localparam logic [OP_W-1:0] OP_JAL  = 4'hD;
    localparam logic [OP_W-1:0] OP_RSVD = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [FS_W-1:0] FS_ZERO  = 4'h0;
    localparam logic [FS_W-1:0] FS_ADD   = 4'h1;
    localparam logic [FS_W-1:0] FS_SUB   = 4'h2;
    localparam logic [FS_W-1:0] FS_AND   = 4'h3;
    localparam logic [FS_W-1:0] FS_OR    = 4'h4;
    localparam logic [FS_W-1:0] FS_XOR   = 4'h5;
    localparam logic [FS_W-1:0] FS_PASSA = 4'h6;
    localparam logic [FS_W-1:0] FS_PASSB = 4'h7;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef struct packed {
        logic [FS_W-1:0] fs;
        logic            mb;
        logic            md;
        logic            mp;
        logic            rw_en;
        logic            is_mem;
        logic            is_st;
        logic            is_br;
        logic            br_pol;
        logic            is_jmp;
        logic            is_halt;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode; state gating of RW/requests is left to control_unit.
module instr_decoder
    import cu_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output dec_t            dec_o
);

    always_comb begin
        dec_o    = '0;
        dec_o.fs = FS_ZERO;
        case (op_i)
            OP_ADD:  begin dec_o.fs = FS_ADD;   dec_o.rw_en = 1'b1; end
            OP_SUB:  begin dec_o.fs = FS_SUB;   dec_o.rw_en = 1'b1; end
            OP_AND:  begin dec_o.fs = FS_AND;   dec_o.rw_en = 1'b1; end
            OP_OR:   begin dec_o.fs = FS_OR;    dec_o.rw_en = 1'b1; end
            OP_XOR:  begin dec_o.fs = FS_XOR;   dec_o.rw_en = 1'b1; end
            OP_LDI:  begin dec_o.fs = FS_PASSB; dec_o.mb = 1'b1; dec_o.rw_en = 1'b1; end
            OP_MOV:  begin dec_o.fs = FS_PASSA; dec_o.rw_en = 1'b1; end
            OP_LD:   begin dec_o.is_mem = 1'b1; dec_o.md = 1'b1; dec_o.rw_en = 1'b1; end
            OP_ST:   begin dec_o.is_mem = 1'b1; dec_o.is_st = 1'b1; end
            // Branch condition is Z of PASSA(ra); br_pol is the Z value that takes the branch
            OP_BZ:   begin dec_o.fs = FS_PASSA; dec_o.is_br = 1'b1; dec_o.br_pol = 1'b1; end
            OP_BNZ:  begin dec_o.fs = FS_PASSA; dec_o.is_br = 1'b1; end
            OP_JMP:  begin dec_o.fs = FS_PASSA; dec_o.is_jmp = 1'b1; end
            OP_JAL:  begin
                dec_o.fs     = FS_PASSA;
                dec_o.is_jmp = 1'b1;
                dec_o.mp     = 1'b1;
                dec_o.rw_en  = 1'b1;
            end
            OP_HALT: dec_o.is_halt = 1'b1;
            OP_NOP, OP_RSVD: dec_o = '0;
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/execute sequencer: owns PC and IR, drives datapath controls
// and the instruction (req/valid) and data (req/ack) memory ports.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned     PC_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk_main,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               instr_valid,
    output logic               instr_req,
    output logic [PC_W-1:0]    pc_out,
    output logic               data_req,
    output logic               data_we,
    input  logic               data_ack,
    input  logic               Z,
    input  logic [INSTR_W-1:0] BusA,
    output logic [REG_W-1:0]   DR,
    output logic [REG_W-1:0]   SA,
    output logic [REG_W-1:0]   SB,
    output logic [FS_W-1:0]    FS,
    output logic               MB,
    output logic               MD,
    output logic               RW,
    output logic               MP,
    output logic [PC_W-1:0]    PC_link,
    output logic               halted
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_br;
    dec_t               dec;
    logic               unused_busa;

    instr_decoder u_dec (
        .op_i  (ir_q[15:12]),
        .dec_o (dec)
    );

    // All PC arithmetic wraps naturally at PC_W bits
    assign pc_inc      = pc_q + PC_W'(1);
    assign pc_br       = pc_inc + {{(PC_W-REG_W){ir_q[11]}}, ir_q[11:8]};
    assign pc_out      = pc_q;
    assign PC_link     = pc_inc;
    assign unused_busa = ^BusA[INSTR_W-1:PC_W];

    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instr_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        DR        = '0;
        SA        = '0;
        SB        = '0;
        FS        = FS_ZERO;
        MB        = 1'b0;
        MD        = 1'b0;
        RW        = 1'b0;
        MP        = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                DR      = ir_q[11:8];
                SA      = ir_q[7:4];
                SB      = ir_q[3:0];
                FS      = dec.fs;
                MB      = dec.mb;
                MP      = dec.mp;
                // Loads write back from MEM on ack, never here
                RW      = dec.rw_en & ~dec.is_mem;
                pc_d    = pc_inc;
                state_d = ST_FETCH;
                if (dec.is_mem) begin
                    pc_d    = pc_q;
                    state_d = ST_MEM;
                end else if (dec.is_halt) begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end else if (dec.is_jmp) begin
                    pc_d = BusA[PC_W-1:0];
                end else if (dec.is_br && (Z == dec.br_pol)) begin
                    pc_d = pc_br;
                end
            end

            ST_MEM: begin
                data_req = 1'b1;
                data_we  = dec.is_st;
                DR       = ir_q[11:8];
                SA       = ir_q[7:4];
                SB       = ir_q[3:0];
                MD       = dec.md;
                RW       = data_ack & dec.rw_en;
                if (data_ack) begin
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
            end

            default: state_d = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit with a small register-file/ALU/data-memory model standing in for datapath.
module tb_control_unit;
    import cu_pkg::*;

    logic        clk_main;
    logic        reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_req;
    logic [5:0]  pc_out;
    logic        data_req;
    logic        data_we;
    logic        data_ack;
    logic        Z;
    logic [15:0] BusA;
    logic [3:0]  DR, SA, SB, FS;
    logic        MB, MD, RW, MP;
    logic [5:0]  PC_link;
    logic        halted;

    control_unit dut (
        .clk_main    (clk_main),
        .reset       (reset),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_req   (instr_req),
        .pc_out      (pc_out),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_ack    (data_ack),
        .Z           (Z),
        .BusA        (BusA),
        .DR          (DR),
        .SA          (SA),
        .SB          (SB),
        .FS          (FS),
        .MB          (MB),
        .MD          (MD),
        .RW          (RW),
        .MP          (MP),
        .PC_link     (PC_link),
        .halted      (halted)
    );

    initial clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    // Datapath stand-in: 16x16 register file, ALU, 64-word data memory
    logic [15:0] regs [16];
    logic [15:0] dmem [64];
    logic [15:0] bus_a, bus_b, alu_f, data_in;

    always_comb begin
        bus_a = regs[SA];
        bus_b = MB ? {8'h00, SA, SB} : regs[SB];
        case (FS)
            FS_ADD:   alu_f = bus_a + bus_b;
            FS_SUB:   alu_f = bus_a - bus_b;
            FS_AND:   alu_f = bus_a & bus_b;
            FS_OR:    alu_f = bus_a | bus_b;
            FS_XOR:   alu_f = bus_a ^ bus_b;
            FS_PASSA: alu_f = bus_a;
            FS_PASSB: alu_f = bus_b;
            default:  alu_f = 16'h0000;
        endcase
        data_in = dmem[bus_a[5:0]];
    end

    assign Z    = (alu_f == 16'h0000);
    assign BusA = bus_a;

    always @(posedge clk_main or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= 16'h0000;
            for (int i = 0; i < 64; i++) dmem[i] <= 16'hA500 | 16'(i);
        end else begin
            if (RW) regs[DR] <= MP ? {10'b0, PC_link} : (MD ? data_in : alu_f);
            if (data_req && data_we && data_ack) dmem[bus_a[5:0]] <= bus_b;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Fetch one instruction, then run until FETCH/HALT again; memory acks immediately
    task automatic run_instr(input logic [15:0] ins, output int cyc, output int rw_cnt);
        cyc         = 0;
        rw_cnt      = 0;
        instr_in    = ins;
        instr_valid = 1'b1;
        @(posedge clk_main); #1;
        instr_valid = 1'b0;
        cyc = 1;
        while (!instr_req && !halted && cyc < 20) begin
            if (data_req) begin
                data_ack = 1'b1;
                #1;
            end
            if (RW) rw_cnt++;
            @(posedge clk_main); #1;
            data_ack = 1'b0;
            cyc++;
        end
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  dst;
        logic        wr;
        logic [15:0] val;
        logic [5:0]  pc;
        int          cyc;
    } vec_t;

    localparam int unsigned NVEC = 25;
    vec_t tbl [NVEC];

    initial begin
        int cyc, rw_cnt;
        int n_req, n_rw, n_pc, n_md, n_we, n_halt, n_dreq;
        logic rw_md_ack;

        tbl[0]  = '{16'h612A, 4'd1,  1'b1, 16'h002A, 6'd1,  2};  // LDI R1,0x2A
        tbl[1]  = '{16'h1211, 4'd2,  1'b1, 16'h0054, 6'd2,  2};  // ADD R2,R1,R1
        tbl[2]  = '{16'hAC00, 4'd0,  1'b0, 16'h0000, 6'd63, 2};  // BZ -4 on R0: 2+1-4 wraps
        tbl[3]  = '{16'h6505, 4'd5,  1'b1, 16'h0005, 6'd0,  2};  // LDI R5,5; 63+1 wraps
        tbl[4]  = '{16'h6602, 4'd6,  1'b1, 16'h0002, 6'd1,  2};
        tbl[5]  = '{16'h670A, 4'd7,  1'b1, 16'h000A, 6'd2,  2};
        tbl[6]  = '{16'hAC50, 4'd0,  1'b0, 16'h0000, 6'd3,  2};  // BZ on R5!=0: not taken
        tbl[7]  = '{16'hBC50, 4'd0,  1'b0, 16'h0000, 6'd0,  2};  // BNZ on R5: 3+1-4
        tbl[8]  = '{16'hB500, 4'd0,  1'b0, 16'h0000, 6'd1,  2};  // BNZ on R0: not taken
        tbl[9]  = '{16'hA300, 4'd0,  1'b0, 16'h0000, 6'd5,  2};  // BZ +3 on R0: 1+1+3
        tbl[10] = '{16'h6120, 4'd1,  1'b1, 16'h0020, 6'd6,  2};
        tbl[11] = '{16'hC070, 4'd0,  1'b0, 16'h0000, 6'd10, 2};  // JMP R7
        tbl[12] = '{16'hDF10, 4'd15, 1'b1, 16'h000B, 6'd32, 2};  // JAL R15,R1
        tbl[13] = '{16'hC0F0, 4'd0,  1'b0, 16'h0000, 6'd11, 2};  // JMP R15
        tbl[14] = '{16'hD110, 4'd1,  1'b1, 16'h000C, 6'd32, 2};  // JAL R1,R1 reads R1 pre-write
        tbl[15] = '{16'h2325, 4'd3,  1'b1, 16'h004F, 6'd33, 2};
        tbl[16] = '{16'h3425, 4'd4,  1'b1, 16'h0004, 6'd34, 2};
        tbl[17] = '{16'h4825, 4'd8,  1'b1, 16'h0055, 6'd35, 2};
        tbl[18] = '{16'h5922, 4'd9,  1'b1, 16'h0000, 6'd36, 2};
        tbl[19] = '{16'h7A20, 4'd10, 1'b1, 16'h0054, 6'd37, 2};
        tbl[20] = '{16'h0FFF, 4'd0,  1'b0, 16'h0000, 6'd38, 2};  // NOP
        tbl[21] = '{16'hE123, 4'd0,  1'b0, 16'h0000, 6'd39, 2};  // reserved
        tbl[22] = '{16'h9012, 4'd0,  1'b0, 16'h0000, 6'd40, 3};  // ST M[R1=12]=R2
        tbl[23] = '{16'h8B10, 4'd11, 1'b1, 16'h0054, 6'd41, 3};  // LD R11,[R1] reads it back
        tbl[24] = '{16'h2C52, 4'd12, 1'b1, 16'hFFB1, 6'd42, 2};  // SUB 5-0x54

        reset = 1'b1; instr_in = 16'h0000; instr_valid = 1'b0; data_ack = 1'b0;
        repeat (2) @(posedge clk_main);
        #1;
        check("rst_instr_req", 32'(instr_req), 32'd1);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_pc_link", 32'(PC_link), 32'd1);
        check("rst_ctrl", 32'({DR, SA, SB, FS, MB, MD, MP, RW, data_req, data_we, halted}), 32'd0);

        // Idle FETCH with a stray data_ack that must be ignored
        @(negedge clk_main);
        reset = 1'b0; data_ack = 1'b1;
        n_req = 0; n_rw = 0; n_pc = 0;
        repeat (5) begin
            @(posedge clk_main); #1;
            if (instr_req) n_req++;
            if (RW) n_rw++;
            if (pc_out == 6'd0) n_pc++;
        end
        data_ack = 1'b0;
        check("idle_instr_req", 32'(n_req), 32'd5);
        check("idle_rw", 32'(n_rw), 32'd0);
        check("idle_pc", 32'(n_pc), 32'd5);

        for (int i = 0; i < int'(NVEC); i++) begin
            run_instr(tbl[i].ins, cyc, rw_cnt);
            check($sformatf("v%0d_pc", i), 32'(pc_out), 32'(tbl[i].pc));
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            check($sformatf("v%0d_rw_pulses", i), 32'(rw_cnt), 32'(tbl[i].wr));
            if (tbl[i].wr)
                check($sformatf("v%0d_reg", i), 32'(regs[tbl[i].dst]), 32'(tbl[i].val));
        end

        // LD R3,[R7] with ack delayed: 4 MEM cycles, write only in the ack cycle
        instr_in = 16'h8370; instr_valid = 1'b1;
        @(posedge clk_main); #1;
        instr_valid = 1'b0;
        check("ld_exec_req", 32'({data_req, RW}), 32'd0);
        @(posedge clk_main); #1;
        n_dreq = 0; n_rw = 0; n_md = 0; n_we = 0; rw_md_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) data_ack = 1'b1;
            #1;
            if (data_req) n_dreq++;
            if (RW) n_rw++;
            if (MD) n_md++;
            if (data_we) n_we++;
            if (k == 3) rw_md_ack = RW & MD;
            @(posedge clk_main); #1;
            data_ack = 1'b0;
        end
        check("ld_req_cycles", 32'(n_dreq), 32'd4);
        check("ld_rw_pulses", 32'(n_rw), 32'd1);
        check("ld_rw_md_at_ack", 32'(rw_md_ack), 32'd1);
        check("ld_md_cycles", 32'(n_md), 32'd4);
        check("ld_we", 32'(n_we), 32'd0);
        check("ld_back_fetch", 32'({instr_req, data_req}), 32'b10);
        check("ld_pc", 32'(pc_out), 32'd43);
        check("ld_r3", 32'(regs[3]), 32'h0000_A50A);

        // Reset asserted mid-MEM drops data_req at once
        instr_in = 16'h8370; instr_valid = 1'b1;
        @(posedge clk_main); #1;
        instr_valid = 1'b0;
        @(posedge clk_main); #1;
        check("mem_req_before_rst", 32'(data_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mem_data_req", 32'(data_req), 32'd0);
        check("rst_mem_pc", 32'(pc_out), 32'd0);
        check("rst_mem_instr_req", 32'(instr_req), 32'd1);
        @(negedge clk_main);
        reset = 1'b0;
        @(posedge clk_main); #1;
        check("post_rst_fetch", 32'({instr_req, pc_out}), 32'({1'b1, 6'd0}));

        // HALT is absorbing; offered instructions and acks are ignored
        run_instr(16'hF000, cyc, rw_cnt);
        check("halt_enter", 32'({halted, instr_req, pc_out}), 32'({1'b1, 1'b0, 6'd0}));
        instr_in = 16'h612A; instr_valid = 1'b1; data_ack = 1'b1;
        n_halt = 0; n_req = 0; n_dreq = 0; n_rw = 0;
        repeat (5) begin
            @(posedge clk_main); #1;
            if (halted) n_halt++;
            if (instr_req) n_req++;
            if (data_req) n_dreq++;
            if (RW) n_rw++;
        end
        instr_valid = 1'b0; data_ack = 1'b0;
        check("halt_sticks", 32'(n_halt), 32'd5);
        check("halt_no_req", 32'(n_req + n_dreq + n_rw), 32'd0);
        check("halt_pc", 32'(pc_out), 32'd0);
        reset = 1'b1;
        #1;
        check("halt_reset_exit", 32'({halted, instr_req}), 32'b01);
        @(negedge clk_main);
        reset = 1'b0;
        @(posedge clk_main); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
